// File: rtl/tri_point_sequencer.sv
// Feeds a fixed vertex table into the triangle rasteriser, queues emitted points
// in a small FIFO and paces them onto the display port, HOLD cycles per point.
module tri_point_sequencer #(
  parameter int NUM_TRI = 4,
  parameter int HOLD    = 8,
  parameter int DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  output logic       nt,
  output logic [2:0] xi,
  output logic [2:0] yi,
  output logic       disp_valid,
  output logic [2:0] disp_x,
  output logic [2:0] disp_y,
  output logic [1:0] tri_idx,
  output logic       done,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [1:0] LAST_IDX  = 2'(NUM_TRI - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD0, LOAD1, LOAD2, WAIT_BUSY, RUN, NEXT, DRAIN, DONE
  } state_t;

  state_t      state_reg;
  logic [1:0]  wait_cnt_reg;
  logic [7:0]  hold_cnt_reg;
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [5:0]  mem [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic run_clear;

  function automatic logic [5:0] vertex(input logic [1:0] t, input logic [1:0] v);
    logic [5:0] r;
    case ({t, v})
      4'h0: r = {3'd0, 3'd0};
      4'h1: r = {3'd3, 3'd0};
      4'h2: r = {3'd0, 3'd3};
      4'h4: r = {3'd1, 3'd1};
      4'h5: r = {3'd5, 3'd1};
      4'h6: r = {3'd1, 3'd5};
      4'h8: r = {3'd2, 3'd0};
      4'h9: r = {3'd6, 3'd4};
      4'hA: r = {3'd2, 3'd4};
      default: r = {3'd7, 3'd7};  // T3 is degenerate: all vertices at (7,7)
    endcase
    return r;
  endfunction

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && (!disp_valid || hold_cnt_reg == 8'd0);
  // A full FIFO still accepts a point when the display frees a slot that cycle.
  assign push       = po && (!fifo_full || pop);
  assign run_clear  = start && (state_reg == IDLE || state_reg == DONE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {xo, yo};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 2'd0;
      nt           <= 1'b0;
      xi           <= 3'd0;
      yi           <= 3'd0;
      tri_idx      <= 2'd0;
      done         <= 1'b0;
    end else begin
      nt <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= LOAD0;
            nt         <= 1'b1;
            {xi, yi}   <= vertex(2'd0, 2'd0);
            tri_idx    <= 2'd0;
            done       <= 1'b0;
          end
        end
        LOAD0: begin
          state_reg <= LOAD1;
          {xi, yi}  <= vertex(tri_idx, 2'd1);
        end
        LOAD1: begin
          state_reg <= LOAD2;
          {xi, yi}  <= vertex(tri_idx, 2'd2);
        end
        LOAD2: begin
          state_reg    <= WAIT_BUSY;
          wait_cnt_reg <= 2'd0;
        end
        WAIT_BUSY: begin
          if (busy) begin
            state_reg <= RUN;
          end else if (wait_cnt_reg == 2'd3) begin
            state_reg <= NEXT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 2'd1;
          end
        end
        RUN: begin
          if (!busy) state_reg <= NEXT;
        end
        NEXT: begin
          if (tri_idx == LAST_IDX) begin
            state_reg <= DRAIN;
          end else begin
            state_reg <= LOAD0;
            nt        <= 1'b1;
            {xi, yi}  <= vertex(tri_idx + 2'd1, 2'd0);
            tri_idx   <= tri_idx + 2'd1;
          end
        end
        DRAIN: begin
          if (fifo_empty && !disp_valid) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow     <= 1'b0;
      disp_valid   <= 1'b0;
      disp_x       <= 3'd0;
      disp_y       <= 3'd0;
      hold_cnt_reg <= 8'd0;
    end else begin
      if (pop) begin
        {disp_x, disp_y} <= mem[rd_ptr_reg[AW-1:0]];
        disp_valid       <= 1'b1;
        hold_cnt_reg     <= HOLD_LOAD;
      end else if (disp_valid) begin
        if (hold_cnt_reg == 8'd0) disp_valid <= 1'b0;
        else hold_cnt_reg <= hold_cnt_reg - 8'd1;
      end

      if (run_clear) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (po && !push) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tri_point_sequencer.sv
// Directed bench for tri_point_sequencer: a table of per-cycle expectations for a
// full run, plus hand-written sequences for overflow, ignored start and mid-run reset.
module tb_tri_point_sequencer;
  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       po;
  logic [2:0] xo, yo;
  logic       nt;
  logic [2:0] xi, yi;
  logic       disp_valid;
  logic [2:0] disp_x, disp_y;
  logic [1:0] tri_idx;
  logic       done;
  logic       overflow;

  logic       m_busy, m_po, t_po, model_en;
  logic [2:0] m_xo, m_yo, t_xo, t_yo;

  int tests  = 0;
  int failed = 0;

  assign busy = m_busy;
  assign po   = m_po | t_po;
  assign xo   = m_po ? m_xo : t_xo;
  assign yo   = m_po ? m_yo : t_yo;

  tri_point_sequencer #(.NUM_TRI(4), .HOLD(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .po(po),
    .xo(xo), .yo(yo), .nt(nt), .xi(xi), .yi(yi), .disp_valid(disp_valid),
    .disp_x(disp_x), .disp_y(disp_y), .tri_idx(tri_idx), .done(done),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         rel;
    logic       nt;
    logic [2:0] xi;
    logic [2:0] yi;
    logic [1:0] tidx;
    logic       dv;
    logic [2:0] dx;
    logic [2:0] dy;
    logic       dn;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".nt"}, int'(nt), 0);
    check({tag, ".xi"}, int'(xi), 0);
    check({tag, ".yi"}, int'(yi), 0);
    check({tag, ".dv"}, int'(disp_valid), 0);
    check({tag, ".dx"}, int'(disp_x), 0);
    check({tag, ".dy"}, int'(disp_y), 0);
    check({tag, ".tri"}, int'(tri_idx), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".ovf"}, int'(overflow), 0);
    $display("[TB] %s: reset values checked", tag);
  endtask

  // Triangle model: after each non-degenerate nt, raise busy, emit (v0x+p, v0y) for p=0..2, drop busy.
  initial begin
    logic [2:0] bx, by;
    m_busy = 1'b0; m_po = 1'b0; m_xo = 3'd0; m_yo = 3'd0;
    forever begin
      @(negedge clk);
      if (model_en && nt && !(xi == 3'd7 && yi == 3'd7)) begin
        bx = xi;
        by = yi;
        repeat (4) @(negedge clk);
        m_busy = 1'b1;
        for (int p = 0; p < 3; p++) begin
          @(negedge clk);
          m_po = 1'b1;
          m_xo = bx + 3'(p);
          m_yo = by;
        end
        @(negedge clk);
        m_po   = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ex [10];
    logic [2:0] ey [10];
    int row;

    reset = 1'b1; start = 1'b0; model_en = 1'b0;
    t_po = 1'b0; t_xo = 3'd0; t_yo = 3'd0;

    //          rel nt    xi    yi    tri   dv    dx    dy    done
    vecs[0]  = '{0,  1'b1, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[1]  = '{1,  1'b0, 3'd3, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[2]  = '{2,  1'b0, 3'd0, 3'd3, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[3]  = '{3,  1'b0, 3'd0, 3'd3, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[4]  = '{6,  1'b0, 3'd0, 3'd3, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[5]  = '{7,  1'b0, 3'd0, 3'd3, 2'd0, 1'b1, 3'd0, 3'd0, 1'b0};
    vecs[6]  = '{10, 1'b1, 3'd1, 3'd1, 2'd1, 1'b1, 3'd0, 3'd0, 1'b0};
    vecs[7]  = '{11, 1'b0, 3'd5, 3'd1, 2'd1, 1'b1, 3'd0, 3'd0, 1'b0};
    vecs[8]  = '{15, 1'b0, 3'd1, 3'd5, 2'd1, 1'b1, 3'd1, 3'd0, 1'b0};
    vecs[9]  = '{20, 1'b1, 3'd2, 3'd0, 2'd2, 1'b1, 3'd1, 3'd0, 1'b0};
    vecs[10] = '{21, 1'b0, 3'd6, 3'd4, 2'd2, 1'b1, 3'd1, 3'd0, 1'b0};
    vecs[11] = '{23, 1'b0, 3'd2, 3'd4, 2'd2, 1'b1, 3'd2, 3'd0, 1'b0};
    vecs[12] = '{30, 1'b1, 3'd7, 3'd7, 2'd3, 1'b1, 3'd2, 3'd0, 1'b0};
    vecs[13] = '{31, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd1, 3'd1, 1'b0};
    vecs[14] = '{39, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd2, 3'd1, 1'b0};
    vecs[15] = '{47, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd3, 3'd1, 1'b0};
    vecs[16] = '{55, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd2, 3'd0, 1'b0};
    vecs[17] = '{63, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd3, 3'd0, 1'b0};
    vecs[18] = '{71, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[19] = '{78, 1'b0, 3'd7, 3'd7, 2'd3, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[20] = '{79, 1'b0, 3'd7, 3'd7, 2'd3, 1'b0, 3'd4, 3'd0, 1'b0};
    vecs[21] = '{80, 1'b0, 3'd7, 3'd7, 2'd3, 1'b0, 3'd4, 3'd0, 1'b1};

    // Overflow burst points: P0 then B1..B9 (B10 is the dropped one)
    ex[0] = 3'd7; ey[0] = 3'd0;
    for (int i = 1; i < 10; i++) begin
      ex[i] = 3'(i);
      ey[i] = (i >= 8) ? 3'd5 : 3'd4;
    end

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Full run with the triangle model; start pulsed during RUN at rel 5 must be ignored.
    @(negedge clk);
    start = 1'b1;
    model_en = 1'b1;
    row = 0;
    for (int rel = 0; rel <= 80; rel++) begin
      @(negedge clk);
      if (row < NV && vecs[row].rel == rel) begin
        check($sformatf("v%0d.nt", row),   int'(nt),         int'(vecs[row].nt));
        check($sformatf("v%0d.xi", row),   int'(xi),         int'(vecs[row].xi));
        check($sformatf("v%0d.yi", row),   int'(yi),         int'(vecs[row].yi));
        check($sformatf("v%0d.tri", row),  int'(tri_idx),    int'(vecs[row].tidx));
        check($sformatf("v%0d.dv", row),   int'(disp_valid), int'(vecs[row].dv));
        check($sformatf("v%0d.dx", row),   int'(disp_x),     int'(vecs[row].dx));
        check($sformatf("v%0d.dy", row),   int'(disp_y),     int'(vecs[row].dy));
        check($sformatf("v%0d.done", row), int'(done),       int'(vecs[row].dn));
        check($sformatf("v%0d.ovf", row),  int'(overflow),   0);
        $display("[TB] vec %0d rel %0d nt=%0b xi=%0d yi=%0d tri=%0d dv=%0b d=(%0d,%0d) done=%0b",
                 row, rel, nt, xi, yi, tri_idx, disp_valid, disp_x, disp_y, done);
        row++;
      end
      start = (rel == 5);
    end
    check("table_rows", row, NV);

    // Overflow: P0 into an idle display, then 10 back-to-back points.
    model_en = 1'b0;
    @(negedge clk);
    t_po = 1'b1; t_xo = ex[0]; t_yo = ey[0];
    for (int r = 0; r <= 82; r++) begin
      @(negedge clk);
      if (r == 0) check("ovf.idle_dv", int'(disp_valid), 0);
      if (r == 9) check("ovf.full_pop_push", int'(overflow), 0);
      if (r == 10) check("ovf.drop", int'(overflow), 1);
      for (int i = 0; i < 10; i++) begin
        if (r == 1 + 8 * i || r == 8 + 8 * i) begin
          check($sformatf("ovf.p%0d_r%0d.dv", i, r), int'(disp_valid), 1);
          check($sformatf("ovf.p%0d_r%0d.dx", i, r), int'(disp_x), int'(ex[i]));
          check($sformatf("ovf.p%0d_r%0d.dy", i, r), int'(disp_y), int'(ey[i]));
          $display("[TB] ovf r %0d point %0d shown (%0d,%0d)", r, i, disp_x, disp_y);
        end
      end
      if (r == 81) begin
        check("ovf.end_dv", int'(disp_valid), 0);
        check("ovf.end_dx", int'(disp_x), int'(ex[9]));
        check("ovf.end_dy", int'(disp_y), int'(ey[9]));
      end
      if (r < 10) begin
        t_xo = 3'(r + 1);
        t_yo = ((r + 1) >= 8) ? 3'd5 : 3'd4;
      end else begin
        t_po = 1'b0;
      end
    end
    check("ovf.sticky", int'(overflow), 1);

    // Restart clears overflow; then reset mid-run with points queued.
    @(negedge clk);
    model_en = 1'b1;
    start = 1'b1;
    for (int rel = 0; rel <= 18; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (rel == 0) begin
        check("rs.ovf_clr", int'(overflow), 0);
        check("rs.nt", int'(nt), 1);
        check("rs.tri", int'(tri_idx), 0);
        $display("[TB] restart rel 0 ovf=%0b nt=%0b tri=%0d", overflow, nt, tri_idx);
      end
      if (rel == 11) begin
        t_po = 1'b1; t_xo = 3'd5; t_yo = 3'd5;
      end
      if (rel == 12) t_po = 1'b0;
      if (rel == 18) begin
        check("mr.dv_before", int'(disp_valid), 1);
        check("mr.tri_before", int'(tri_idx), 1);
        model_en = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals("midrun");
      end
    end
    @(negedge clk);
    reset = 1'b0;

    // Restart from T0 with busy never rising: every entry times out.
    @(negedge clk);
    start = 1'b1;
    for (int rel = 0; rel <= 33; rel++) begin
      @(negedge clk);
      start = 1'b0;
      if (rel == 0) begin
        check("to.nt0", int'(nt), 1);
        check("to.xi0", int'(xi), 0);
        check("to.yi0", int'(yi), 0);
        check("to.tri0", int'(tri_idx), 0);
        check("to.dv0", int'(disp_valid), 0);
      end
      if (rel == 7) begin
        check("to.next_nt", int'(nt), 0);
        check("to.next_tri", int'(tri_idx), 0);
      end
      if (rel == 8 || rel == 16 || rel == 24) begin
        check($sformatf("to.r%0d.nt", rel), int'(nt), 1);
        check($sformatf("to.r%0d.tri", rel), int'(tri_idx), rel / 8);
        $display("[TB] timeout run rel %0d tri=%0d xi=%0d yi=%0d", rel, tri_idx, xi, yi);
      end
      if (rel == 8)  check("to.xi1", int'(xi), 1);
      if (rel == 16) check("to.xi2", int'(xi), 2);
      if (rel == 24) check("to.xi3", int'(xi), 7);
      if (rel == 32) check("to.drain_done", int'(done), 0);
      if (rel == 33) begin
        check("to.done", int'(done), 1);
        check("to.tri3", int'(tri_idx), 3);
        check("to.dv", int'(disp_valid), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/tri_point_sequencer.md
# tri_point_sequencer

Controller that sequences the `triangle` rasteriser and paces its output for the seven-segment display. It feeds a fixed table of triangle vertex sets into `triangle` over the nt/xi/yi handshake, captures every emitted point (po/xo/yo) into a small FIFO, and presents each point on a display port for a fixed number of clock cycles. It sits between `triangle` and the display multiplexer in `top`, and runs on the divided `count_clk`.

## Interface
- `NUM_TRI`, default 4: number of table entries processed per run; legal range 1..4.
- `HOLD`, default 8: cycles each point is held on the display port; legal range 2..255.
- `DEPTH`, default 8: point FIFO depth; must be a power of 2.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: single-cycle request to begin a run; honoured only in IDLE or DONE.
- `busy` in 1: from `triangle`; high while it is rasterising.
- `po` in 1: from `triangle`; point-valid strobe.
- `xo`, `yo` in 3 each: point coordinates from `triangle`, valid when `po`=1.
- `nt` out 1: new-triangle strobe to `triangle`.
- `xi`, `yi` out 3 each: vertex coordinates to `triangle`.
- `disp_valid` out 1: a point is being shown.
- `disp_x`, `disp_y` out 3 each: the point being shown.
- `tri_idx` out 2: index of the current table entry.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; a point was dropped because the FIFO was full.

## Operation
- Vertex table, given as (x,y) for v0, v1, v2:
  - T0: (0,0) (3,0) (0,3)
  - T1: (1,1) (5,1) (1,5)
  - T2: (2,0) (6,4) (2,4)
  - T3: (7,7) (7,7) (7,7), a degenerate entry.
- States: IDLE, LOAD0, LOAD1, LOAD2, WAIT_BUSY, RUN, NEXT, DRAIN, DONE.
- IDLE/DONE --start--> LOAD0. Entering from `start` clears `tri_idx`, `overflow` and the FIFO.
- LOAD0: `nt`=1 and xi/yi = v0. LOAD1: xi/yi = v1. LOAD2: xi/yi = v2. Each state lasts exactly one cycle, and `nt`=0 outside LOAD0.
- WAIT_BUSY: go to RUN on `busy`=1. If `busy` has not risen within 4 cycles of entry, go to NEXT; this covers degenerate triangles.
- RUN: go to NEXT on `busy`=0.
- NEXT: if `tri_idx`=NUM_TRI-1 go to DRAIN; otherwise increment `tri_idx` and go to LOAD0.
- DRAIN: go to DONE once the FIFO is empty and `disp_valid`=0.
- `start` is ignored in every state except IDLE and DONE.
- Capture:
  - Every cycle with `po`=1 pushes {xo,yo}, in any state.
  - If the FIFO is full and no pop happens that cycle, the point is dropped and `overflow` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- Display pacing:
  - A hold counter loads HOLD-1 when a point is popped into disp_x/disp_y, and `disp_valid` goes to 1.
  - When the counter reaches 0 and the FIFO is non-empty, the next point is popped back-to-back. If the FIFO is empty, `disp_valid` goes to 0 and disp_x/disp_y keep their last value.
  - While `disp_valid`=0 and the FIFO is non-empty, a pop happens on the next edge.
- FIFO pointers carry one extra wrap bit. Full and empty are decided by comparing pointers; wrap-around is modulo DEPTH.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `nt`=0, xi=yi=0, `disp_valid`=0, disp_x=disp_y=0, `tri_idx`=0, `done`=0, `overflow`=0, FIFO empty.
- Reset asserted mid-run returns to the reset values immediately (asynchronously). FIFO contents are discarded.
- `start` sampled at edge k: `nt`=1 with v0 during cycle k+1, v1 during cycle k+2, v2 during cycle k+3, and state WAIT_BUSY from cycle k+4.
- `po` sampled at edge e with the FIFO empty and the display idle: `disp_valid`=1 with that point from edge e+1 for exactly HOLD cycles.
- Back-to-back points: `disp_valid` stays 1 continuously and disp_x/disp_y change every HOLD cycles.
- `done` rises 1 cycle after the DRAIN exit condition is met.

## Test plan
- Reset then `start`, with `triangle` modelled to assert `busy` 2 cycles after LOAD2 and emit 3 points: nt/xi/yi show (0,0),(3,0),(0,3) on cycles k+1..k+3 -> 3 points are displayed HOLD=8 cycles each, contiguously -> after all 4 table entries, `done`=1 and `tri_idx`=3.
- `busy` never rises for T3: WAIT_BUSY times out after 4 cycles -> NEXT -> DRAIN, no hang.
- 10 consecutive `po` pulses with DEPTH=8 while a point is being held -> exactly 1 pop-free overflow drop -> `overflow`=1, 9 points are displayed in order. `overflow` clears on the next `start`.
- `po` arrives in the same cycle the hold expires with the FIFO full -> push accepted, no overflow.
- `start` pulsed in RUN -> ignored, and the sequence of `tri_idx` is unchanged.
- `reset` asserted during RUN with 5 points queued -> all outputs return to their reset values in the same cycle, `disp_valid`=0, and after `start` the run restarts at T0.
